// File: rtl/bram_test_ctrl.sv
// bram_test_ctrl: writes an address-derived pattern through RAM port A, reads it
// back through port B and reports the mismatch count and first failing address.
module bram_test_ctrl #(
   parameter int                ADDR_W  = 9,
   parameter int                DATA_W  = 16,
   parameter logic [DATA_W-1:0] PATTERN = 16'hA5A5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] dina,
   output logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] doutb,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] err_addr
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   logic [2:0]        state_q,     state_d;
   logic              wea_q,       wea_d;
   logic [ADDR_W-1:0] addra_q,     addra_d;
   logic [DATA_W-1:0] dina_q,      dina_d;
   logic [ADDR_W-1:0] addrb_q,     addrb_d;
   logic              vld_p1_q,    vld_p1_d;
   logic [ADDR_W-1:0] addr_p1_q,   addr_p1_d;
   logic [ADDR_W:0]   err_cnt_q,   err_cnt_d;
   logic [ADDR_W-1:0] err_addr_q,  err_addr_d;
   logic              first_err_q, first_err_d;
   logic              mismatch;

   function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) ^ PATTERN;
   endfunction

   // The read pipeline stage lines up the address with the RAM's one-cycle read latency.
   assign mismatch = vld_p1_q && (doutb != exp_word(addr_p1_q));

   always_comb begin
      state_d     = state_q;
      wea_d       = wea_q;
      addra_d     = addra_q;
      dina_d      = dina_q;
      addrb_d     = addrb_q;
      err_cnt_d   = err_cnt_q;
      err_addr_d  = err_addr_q;
      first_err_d = first_err_q;
      vld_p1_d    = (state_q == S_READ);
      addr_p1_d   = addrb_q;

      if (mismatch) begin
         err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
         if (!first_err_q) begin
            err_addr_d  = addr_p1_q;
            first_err_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_WRITE;
               wea_d       = 1'b1;
               addra_d     = '0;
               dina_d      = exp_word('0);
               err_cnt_d   = '0;
               err_addr_d  = '0;
               first_err_d = 1'b0;
            end
         end
         S_WRITE: begin
            if (addra_q == LAST_ADDR) begin
               state_d = S_READ;
               wea_d   = 1'b0;
               addrb_d = '0;
            end else begin
               addra_d = addra_q + ADDR_W'(1);
               dina_d  = exp_word(addra_q + ADDR_W'(1));
            end
         end
         S_READ: begin
            if (addrb_q == LAST_ADDR) state_d = S_CHECK;
            else                      addrb_d = addrb_q + ADDR_W'(1);
         end
         S_CHECK: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wea_q       <= 1'b0;
         addra_q     <= '0;
         dina_q      <= '0;
         addrb_q     <= '0;
         vld_p1_q    <= 1'b0;
         addr_p1_q   <= '0;
         err_cnt_q   <= '0;
         err_addr_q  <= '0;
         first_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wea_q       <= wea_d;
         addra_q     <= addra_d;
         dina_q      <= dina_d;
         addrb_q     <= addrb_d;
         vld_p1_q    <= vld_p1_d;
         addr_p1_q   <= addr_p1_d;
         err_cnt_q   <= err_cnt_d;
         err_addr_q  <= err_addr_d;
         first_err_q <= first_err_d;
      end
   end

   assign wea      = wea_q;
   assign addra    = addra_q;
   assign dina     = dina_q;
   assign addrb    = addrb_q;
   assign busy     = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_CHECK);
   assign done     = (state_q == S_DONE);
   assign pass     = done && (err_cnt_q == '0);
   assign err_cnt  = err_cnt_q;
   assign err_addr = err_addr_q;
endmodule

// File: tb/tb_bram_test_ctrl.sv
// Bench for bram_test_ctrl: behavioural RAM with injectable read corruption and a
// schedule/result reference model derived from the cycle plan of a test run.
module tb_bram_test_ctrl;
   localparam int          ADDR_W = 9;
   localparam int          DATA_W = 16;
   localparam int          DEPTH  = 512;
   localparam logic [15:0] PAT    = 16'hA5A5;
   localparam int          LOGN   = 1100;
   localparam int          RUNLEN = 1030;

   logic              clk = 1'b0;
   logic              rst, start;
   logic              wea;
   logic [ADDR_W-1:0] addra, addrb, err_addr;
   logic [DATA_W-1:0] dina, doutb;
   logic              busy, done, pass;
   logic [ADDR_W:0]   err_cnt;

   logic [15:0] mem     [DEPTH];
   logic [15:0] corrupt [DEPTH];

   logic        l_wea   [LOGN];
   logic [8:0]  l_addra [LOGN];
   logic [15:0] l_dina  [LOGN];
   logic [8:0]  l_addrb [LOGN];
   logic        l_busy  [LOGN];
   logic        l_done  [LOGN];

   int cyc;
   int pulse_a = -1, pulse_b = -1;
   int n_vec = 0, n_err = 0;

   bram_test_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PATTERN(PAT)) dut (
      .clk(clk), .rst(rst), .start(start), .wea(wea), .addra(addra), .dina(dina),
      .addrb(addrb), .doutb(doutb), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   // Ideal dual-port RAM; the read path XORs in the corruption mask of the address.
   always @(posedge clk) begin
      if (wea) mem[addra] <= dina;
      doutb <= mem[addrb] ^ corrupt[addrb];
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < LOGN) begin
         l_wea[cyc]   = wea;
         l_addra[cyc] = addra;
         l_dina[cyc]  = dina;
         l_addrb[cyc] = addrb;
         l_busy[cyc]  = busy;
         l_done[cyc]  = done;
      end
   endtask

   task automatic launch();
      cyc   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_rest();
      while (cyc < RUNLEN) begin
         start = (cyc == pulse_a) || (cyc == pulse_b);
         step();
      end
      start = 1'b0;
   endtask

   task automatic clear_corrupt();
      for (int i = 0; i < DEPTH; i++) corrupt[i] = 16'h0;
   endtask

   // Expected run plan: cycle c (c=1 right after start is sampled) writes address c-1
   // for c<=512, reads address c-513 for 513..1024, checks at 1025, done from 1026.
   function automatic int sched_errs();
      int n = 0;
      for (int c = 1; c <= RUNLEN; c++) begin
         logic ew;
         logic [15:0] ed;
         ew = (c <= 512);
         ed = 16'(c - 1) ^ PAT;
         if (l_wea[c] !== ew) n++;
         if (ew && (l_addra[c] !== 9'(c - 1) || l_dina[c] !== ed)) n++;
         if (c > 512 && l_addra[c] !== 9'd511) n++;
         if (c >= 513 && c <= 1024 && l_addrb[c] !== 9'(c - 513)) n++;
         if (c > 1024 && l_addrb[c] !== 9'd511) n++;
         if (l_busy[c] !== (c <= 1025)) n++;
         if (l_done[c] !== (c >= 1026)) n++;
      end
      return n;
   endfunction

   function automatic int model_cnt();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (corrupt[i] != 16'h0) n++;
      return n;
   endfunction

   function automatic int model_first();
      for (int i = 0; i < DEPTH; i++) if (corrupt[i] != 16'h0) return i;
      return 0;
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      step(); step();
      n_vec++; if (wea !== 1'b0)       begin n_err++; $display("FAIL reset_wea got=%b exp=0", wea); end
      n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_vec++; if (pass !== 1'b0)      begin n_err++; $display("FAIL reset_pass got=%b exp=0", pass); end
      n_vec++; if (err_cnt !== 10'd0)  begin n_err++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      n_vec++; if (err_addr !== 9'd0)  begin n_err++; $display("FAIL reset_err_addr got=%0d exp=0", err_addr); end
      n_vec++; if (addra !== 9'd0)     begin n_err++; $display("FAIL reset_addra got=%0d exp=0", addra); end
      n_vec++; if (dina !== 16'd0)     begin n_err++; $display("FAIL reset_dina got=%h exp=0", dina); end
      n_vec++; if (addrb !== 9'd0)     begin n_err++; $display("FAIL reset_addrb got=%0d exp=0", addrb); end
      rst = 1'b0; start = 1'b0;
      step();
      n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_clean_run();
      int se;
      clear_corrupt();
      launch(); run_rest();
      se = sched_errs();
      n_vec++; if (se !== 0) begin n_err++; $display("FAIL clean_schedule bad_cycles=%0d exp=0", se); end
      n_vec++; if (l_dina[1] !== 16'hA5A5)   begin n_err++; $display("FAIL clean_dina0 got=%h exp=a5a5", l_dina[1]); end
      n_vec++; if (l_dina[512] !== 16'hA45A) begin n_err++; $display("FAIL clean_dina511 got=%h exp=a45a", l_dina[512]); end
      n_vec++; if (l_done[1025] !== 1'b0 || l_done[1026] !== 1'b1)
         begin n_err++; $display("FAIL clean_done_edge got=%b%b exp=01", l_done[1025], l_done[1026]); end
      n_vec++; if (pass !== 1'b1)     begin n_err++; $display("FAIL clean_pass got=%b exp=1", pass); end
      n_vec++; if (err_cnt !== 10'd0) begin n_err++; $display("FAIL clean_err_cnt got=%0d exp=0", err_cnt); end
      n_vec++; if (err_addr !== 9'd0) begin n_err++; $display("FAIL clean_err_addr got=%0d exp=0", err_addr); end
   endtask

   task automatic test_corrupt(input string name, input int a0, input int a1);
      int se;
      clear_corrupt();
      if (a0 >= 0) corrupt[a0] = 16'(1 << $urandom_range(0, 15));
      if (a1 >= 0) corrupt[a1] = 16'($urandom_range(1, 65535));
      launch(); run_rest();
      se = sched_errs();
      n_vec++; if (se !== 0) begin n_err++; $display("FAIL %s_schedule bad_cycles=%0d exp=0", name, se); end
      n_vec++; if (err_cnt !== 10'(model_cnt()))
         begin n_err++; $display("FAIL %s_err_cnt got=%0d exp=%0d", name, err_cnt, model_cnt()); end
      n_vec++; if (err_addr !== 9'(model_first()))
         begin n_err++; $display("FAIL %s_err_addr got=%0d exp=%0d", name, err_addr, model_first()); end
      n_vec++; if (pass !== (model_cnt() == 0) || done !== 1'b1)
         begin n_err++; $display("FAIL %s_pass_done got=%b%b exp=%b1", name, pass, done, model_cnt() == 0); end
   endtask

   task automatic test_restart_from_done();
      clear_corrupt();
      launch();
      n_vec++; if (err_cnt !== 10'd0 || err_addr !== 9'd0 || done !== 1'b0 || busy !== 1'b1)
         begin n_err++; $display("FAIL restart_clear got cnt=%0d addr=%0d done=%b busy=%b exp 0 0 0 1",
                                 err_cnt, err_addr, done, busy); end
      run_rest();
      n_vec++; if (pass !== 1'b1 || err_cnt !== 10'd0)
         begin n_err++; $display("FAIL restart_pass got pass=%b cnt=%0d exp 1 0", pass, err_cnt); end
   endtask

   task automatic test_ignore_start();
      int se;
      clear_corrupt();
      pulse_a = 10; pulse_b = 700;
      launch(); run_rest();
      pulse_a = -1; pulse_b = -1;
      se = sched_errs();
      n_vec++; if (se !== 0) begin n_err++; $display("FAIL ignore_start_schedule bad_cycles=%0d exp=0", se); end
      n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL ignore_start_pass got=%b exp=1", pass); end
   endtask

   task automatic test_reset_midrun();
      int writes = 0, busies = 0, se;
      clear_corrupt();
      launch();
      while (cyc < 200) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_vec++; if (wea !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
         begin n_err++; $display("FAIL midrst_ctrl got wea=%b busy=%b done=%b pass=%b exp 0", wea, busy, done, pass); end
      n_vec++; if (addra !== 9'd0 || dina !== 16'd0 || addrb !== 9'd0 || err_cnt !== 10'd0 || err_addr !== 9'd0)
         begin n_err++; $display("FAIL midrst_data got addra=%0d dina=%h addrb=%0d cnt=%0d eaddr=%0d exp 0",
                                 addra, dina, addrb, err_cnt, err_addr); end
      for (int i = 0; i < 20; i++) begin
         step();
         if (wea) writes++;
         if (busy) busies++;
      end
      n_vec++; if (writes !== 0 || busies !== 0)
         begin n_err++; $display("FAIL midrst_abort got writes=%0d busy_cycles=%0d exp 0", writes, busies); end
      launch(); run_rest();
      se = sched_errs();
      n_vec++; if (se !== 0 || pass !== 1'b1)
         begin n_err++; $display("FAIL midrst_rerun bad_cycles=%0d pass=%b exp 0 1", se, pass); end
   endtask

   task automatic test_random_runs();
      for (int r = 0; r < 3; r++) begin
         int k, se;
         clear_corrupt();
         k = $urandom_range(0, 6);
         for (int j = 0; j < k; j++) corrupt[$urandom_range(0, DEPTH - 1)] = 16'($urandom_range(1, 65535));
         launch(); run_rest();
         se = sched_errs();
         n_vec++; if (se !== 0) begin n_err++; $display("FAIL rand%0d_schedule bad_cycles=%0d exp=0", r, se); end
         n_vec++; if (err_cnt !== 10'(model_cnt()) || err_addr !== 9'(model_first()))
            begin n_err++; $display("FAIL rand%0d_result got cnt=%0d addr=%0d exp cnt=%0d addr=%0d",
                                    r, err_cnt, err_addr, model_cnt(), model_first()); end
         n_vec++; if (pass !== (model_cnt() == 0))
            begin n_err++; $display("FAIL rand%0d_pass got=%b exp=%b", r, pass, model_cnt() == 0); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cyc = 0;
      clear_corrupt();
      test_reset();
      test_clean_run();
      test_corrupt("corrupt_5_300", 5, 300);
      test_restart_from_done();
      test_ignore_start();
      test_reset_midrun();
      test_corrupt("last_addr", 511, -1);
      test_corrupt("first_addr", 0, -1);
      test_random_runs();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
